// File: rtl/butterfly_16_pipe_pkg.sv
// Shared tq datapath definitions: lane width, lane count, saturation limits and
// the 29-to-28-bit reduction helpers used by the butterfly add/sub pairs.
package butterfly_16_pipe_pkg;

    localparam int unsigned TQ_DW  = 28;
    localparam int unsigned TQ_N16 = 16;

    typedef logic signed [TQ_DW-1:0] lane_t;
    typedef logic signed [TQ_DW:0]   wide_t;

    localparam lane_t TQ_DW_MAX = {1'b0, {(TQ_DW-1){1'b1}}};
    localparam lane_t TQ_DW_MIN = {1'b1, {(TQ_DW-1){1'b0}}};

    function automatic lane_t reduce_wrap(wide_t x);
        return x[TQ_DW-1:0];
    endfunction

    // The top two bits of a 29-bit result disagree exactly when it leaves the 28-bit range.
    function automatic lane_t reduce_sat(wide_t x);
        if (x[TQ_DW] != x[TQ_DW-1]) begin
            return x[TQ_DW] ? TQ_DW_MIN : TQ_DW_MAX;
        end
        return x[TQ_DW-1:0];
    endfunction

endpackage

// File: rtl/butterfly_16_pipe_if.sv
// Row bus of the 16-point butterfly stage: input row with control, registered output row.
interface butterfly_16_pipe_if;
    import butterfly_16_pipe_pkg::*;

    logic  i_valid;
    logic  i_start;
    logic  enable;
    logic  inverse;
    lane_t i_lane [TQ_N16];

    logic       o_valid;
    logic       o_last;
    logic [3:0] o_row;
    lane_t      o_lane [TQ_N16];

    modport master (
        output i_valid, i_start, enable, inverse, i_lane,
        input  o_valid, o_last, o_row, o_lane
    );

    modport slave (
        input  i_valid, i_start, enable, inverse, i_lane,
        output o_valid, o_last, o_row, o_lane
    );

endinterface

// File: rtl/butterfly_16_pipe_bfly_addsub.sv
// One combinational add/subtract pair. Results wrap to 28 bits, or saturate when
// BUTTERFLY16_SAT_EN is defined.
module bfly_addsub
    import butterfly_16_pipe_pkg::*;
(
    input  lane_t a,
    input  lane_t b,
    output lane_t sum,
    output lane_t diff
);

    wide_t sum_w;
    wide_t diff_w;

    assign sum_w  = $signed({a[TQ_DW-1], a}) + $signed({b[TQ_DW-1], b});
    assign diff_w = $signed({a[TQ_DW-1], a}) - $signed({b[TQ_DW-1], b});

`ifdef BUTTERFLY16_SAT_EN
    assign sum  = reduce_sat(sum_w);
    assign diff = reduce_sat(diff_w);
`else
    assign sum  = reduce_wrap(sum_w);
    assign diff = reduce_wrap(diff_w);
`endif

endmodule

// File: rtl/butterfly_16_pipe.sv
// Registered 16-point add/sub butterfly with valid tracking and a 4-bit row counter.
// Overflow handling is selected by BUTTERFLY16_SAT_EN inside bfly_addsub.
module butterfly_16_pipe
    import butterfly_16_pipe_pkg::*;
(
    input logic               clk,
    input logic               rst_n,
    butterfly_16_pipe_if.slave bus
);

    localparam int unsigned Half = TQ_N16 / 2;

    lane_t bf_a    [Half];
    lane_t bf_b    [Half];
    lane_t bf_sum  [Half];
    lane_t bf_diff [Half];
    lane_t res     [TQ_N16];
    lane_t lane_q  [TQ_N16];

    logic [3:0] cnt_q;
    logic [3:0] row_d;
    logic [3:0] row_q;
    logic       valid_q;
    logic       last_q;

    // Forward pairs mirror lanes (k, 15-k); inverse pairs the permuted halves (k, k+8).
    for (genvar k = 0; k < Half; k++) begin : g_pair
        assign bf_a[k] = bus.i_lane[k];
        assign bf_b[k] = bus.inverse ? bus.i_lane[k + Half] : bus.i_lane[TQ_N16 - 1 - k];

        bfly_addsub u_addsub (
            .a    (bf_a[k]),
            .b    (bf_b[k]),
            .sum  (bf_sum[k]),
            .diff (bf_diff[k])
        );

        assign res[k]              = bus.enable ? bf_sum[k]  : bus.i_lane[k];
        assign res[TQ_N16 - 1 - k] = bus.enable ? bf_diff[k] : bus.i_lane[TQ_N16 - 1 - k];
    end

    assign row_d = bus.i_start ? 4'd0 : cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            row_q   <= 4'd0;
            cnt_q   <= 4'd0;
            for (int n = 0; n < TQ_N16; n++) begin
                lane_q[n] <= '0;
            end
        end else begin
            valid_q <= bus.i_valid;
            if (bus.i_valid) begin
                cnt_q  <= row_d + 4'd1;
                row_q  <= row_d;
                last_q <= (row_d == 4'd15);
                for (int n = 0; n < TQ_N16; n++) begin
                    lane_q[n] <= res[n];
                end
            end
        end
    end

    assign bus.o_valid = valid_q;
    assign bus.o_last  = last_q;
    assign bus.o_row   = row_q;

    for (genvar n = 0; n < TQ_N16; n++) begin : g_out
        assign bus.o_lane[n] = lane_q[n];
    end

endmodule

// File: tb/tb_butterfly_16_pipe.sv
// Scoreboard bench for butterfly_16_pipe: directed rows push hand-derived expectations,
// a negedge monitor pops and compares on every o_valid.
module tb_butterfly_16_pipe;
    import butterfly_16_pipe_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    butterfly_16_pipe_if bus ();

    butterfly_16_pipe dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [TQ_N16*TQ_DW-1:0] d;
        logic [3:0]              row;
        logic                    last;
    } exp_t;

    exp_t       q[$];
    exp_t       last_e;
    int         checks = 0;
    int         errors = 0;
    longint     vin  [16];
    longint     vexp [16];
    logic [3:0] exp_cnt = 4'd0;

    function automatic void chk(string nm, longint act, longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endfunction

    task automatic send(bit start, bit en, bit inv);
        exp_t       e;
        logic [3:0] row;
        for (int n = 0; n < 16; n++) begin
            bus.i_lane[n]          = vin[n][TQ_DW-1:0];
            e.d[n*TQ_DW +: TQ_DW]  = vexp[n][TQ_DW-1:0];
        end
        row     = start ? 4'd0 : exp_cnt;
        exp_cnt = row + 4'd1;
        e.row   = row;
        e.last  = (row == 4'd15);
        last_e  = e;
        bus.i_valid = 1'b1;
        bus.i_start = start;
        bus.enable  = en;
        bus.inverse = inv;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Idle cycles with scrambled lanes and a stray i_start; outputs must hold.
    task automatic idle(int ncyc);
        bus.i_valid = 1'b0;
        bus.i_start = 1'b1;
        for (int n = 0; n < 16; n++) bus.i_lane[n] = 28'h5A5A5A5 + n;
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk);
            #1;
            chk("idle o_valid", bus.o_valid, 0);
            chk("idle o_row held", bus.o_row, last_e.row);
            chk("idle o_0 held", bus.o_lane[0], $signed(last_e.d[0 +: TQ_DW]));
            chk("idle o_15 held", bus.o_lane[15], $signed(last_e.d[15*TQ_DW +: TQ_DW]));
        end
        bus.i_start = 1'b0;
    endtask

    task automatic check_zero(string tag);
        chk({tag, " o_valid"}, bus.o_valid, 0);
        chk({tag, " o_last"}, bus.o_last, 0);
        chk({tag, " o_row"}, bus.o_row, 0);
        for (int n = 0; n < 16; n++) begin
            chk($sformatf("%s o_%0d", tag, n), bus.o_lane[n], 0);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.o_valid === 1'b1) begin
                if (q.size() == 0) begin
                    chk("unexpected o_valid", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk($sformatf("row%0d o_row", e.row), bus.o_row, e.row);
                    chk($sformatf("row%0d o_last", e.row), bus.o_last, e.last);
                    for (int n = 0; n < 16; n++) begin
                        chk($sformatf("row%0d o_%0d", e.row, n), bus.o_lane[n],
                            $signed(e.d[n*TQ_DW +: TQ_DW]));
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stim
        bus.i_valid = 1'b0;
        bus.i_start = 1'b0;
        bus.enable  = 1'b0;
        bus.inverse = 1'b0;
        for (int n = 0; n < 16; n++) bus.i_lane[n] = '0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;

        // Forward, i_k = k: o_k = 15, o_(15-k) = 2k - 15
        for (int n = 0; n < 16; n++) vin[n] = n;
        for (int k = 0; k < 8; k++) begin
            vexp[k] = 15;
            vexp[15-k] = 2*k - 15;
        end
        send(1, 1, 0);

        // Inverse, i_k = k: o_k = 2k + 8, o_(15-k) = -8
        for (int k = 0; k < 8; k++) begin
            vexp[k] = 2*k + 8;
            vexp[15-k] = -8;
        end
        send(0, 1, 1);

        // Pass-through with both inverse settings
        for (int n = 0; n < 16; n++) begin
            vin[n]  = 100 + n;
            vexp[n] = 100 + n;
        end
        send(0, 0, 0);
        send(0, 0, 1);

        // Overflow on lanes 0/15; others zero
        for (int n = 0; n < 16; n++) begin
            vin[n]  = 0;
            vexp[n] = 0;
        end
        vin[0]  = 134217727;
        vin[15] = 134217727;
`ifdef BUTTERFLY16_SAT_EN
        vexp[0] = 134217727;
`else
        vexp[0] = -2;
`endif
        vexp[15] = 0;
        send(0, 1, 0);

        // Negative overflow through the inverse pairing: i_0 = min, i_8 = 1
        for (int n = 0; n < 16; n++) begin
            vin[n]  = 0;
            vexp[n] = 0;
        end
        vin[0]  = -134217728;
        vin[8]  = 1;
        vexp[0] = -134217727;
`ifdef BUTTERFLY16_SAT_EN
        vexp[15] = -134217728;
`else
        vexp[15] = 134217727;
`endif
        send(0, 1, 1);

        // i_start on consecutive valid rows
        for (int n = 0; n < 16; n++) vin[n] = n;
        for (int k = 0; k < 8; k++) begin
            vexp[k] = 15;
            vexp[15-k] = 2*k - 15;
        end
        send(1, 1, 0);
        send(1, 1, 0);

        // 17-row block: forward with i_k = 16r + k, gap after row 5
        for (int r = 0; r < 17; r++) begin
            for (int k = 0; k < 8; k++) begin
                vin[k]     = 16*r + k;
                vin[15-k]  = 16*r + 15 - k;
                vexp[k]    = 32*r + 15;
                vexp[15-k] = 2*k - 15;
            end
            send(r == 0, 1, 0);
            if (r == 5) idle(3);
        end
        idle(1);

        // Reset after row 9, with i_valid held high to confirm reset priority
        for (int r = 0; r < 10; r++) begin
            for (int n = 0; n < 16; n++) begin
                vin[n]  = 1000*r + n;
                vexp[n] = 1000*r + n;
            end
            send(r == 0, 0, 0);
        end
        rst_n       = 1'b0;
        bus.i_start = 1'b0;
        @(posedge clk);
        #1;
        check_zero("post-reset");
        rst_n   = 1'b1;
        exp_cnt = 4'd0;
        for (int n = 0; n < 16; n++) begin
            vin[n]  = 7 + n;
            vexp[n] = 7 + n;
        end
        send(0, 0, 0);
        idle(2);

        chk("scoreboard drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
